// File: rtl/attn_dsp_pkg.sv
// Shared constants for the attention DSP datapath.
// Holds the default signed fixed-point format (Q3.12), its saturation
// limits, and the state encoding used by the dot-product accumulator.
package attn_dsp_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 12;

    // Saturation limits of the DATA_W-bit signed Q format.
    localparam logic [DATA_W-1:0] Q_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] Q_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic {
        ST_ACC  = 1'b0,   // collecting products of the current vector
        ST_DONE = 1'b1    // holding the finished sum for downstream
    } acc_state_e;

endpackage

// File: rtl/acc_sat.sv
// Combinational saturation of a wide signed accumulator value down to the
// DATA_W-bit signed Q format.
// Ports:
//   acc_in   - ACC_W-bit signed full-precision sum
//   sat_out  - DATA_W-bit result, clipped to the Q-format range
//   sat_flag - 1 when acc_in was outside the representable range
module acc_sat #(
    parameter int ACC_W  = 24,
    parameter int DATA_W = attn_dsp_pkg::DATA_W
) (
    input  logic [ACC_W-1:0]  acc_in,
    output logic [DATA_W-1:0] sat_out,
    output logic              sat_flag
);

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // The value fits in DATA_W signed bits exactly when every bit from the
    // DATA_W-bit sign position upwards equals the true sign bit.
    logic [ACC_W-DATA_W:0] upper_bits;
    logic                  in_range;

    assign upper_bits = acc_in[ACC_W-1:DATA_W-1];
    assign in_range   = (&upper_bits) | (~|upper_bits);

    always_comb begin
        sat_flag = ~in_range;
        sat_out  = acc_in[DATA_W-1:0];
        if (!in_range) begin
            sat_out = acc_in[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/signedmul_acc.sv
// Signed dot-product accumulator. Accepts VEC_LEN signed Q-format products
// over a valid/ready stream, sums them at ACC_W precision and presents the
// saturated DATA_W-bit result on a second valid/ready stream.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   in_valid/in_ready     - product handshake; prod sampled only on handshake
//   prod                  - signed product (same Q format as sum)
//   out_valid/out_ready   - result handshake
//   sum, sat              - saturated result and clip flag (qualified by out_valid)
//   beat_cnt              - products accepted so far in the current vector
module signedmul_acc #(
    parameter int DATA_W  = attn_dsp_pkg::DATA_W,
    parameter int VEC_LEN = 8,
    parameter int ACC_W   = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              sat,
    output logic [7:0]        beat_cnt
);

    import attn_dsp_pkg::*;

    localparam logic [7:0] LAST_BEAT = 8'(VEC_LEN - 1);

    acc_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              sat_q, sat_d;

    logic              beat_accept;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  acc_sum;
    logic [DATA_W-1:0] sat_val;
    logic              sat_flag;

    // While a result is pending the upstream is only let through when the
    // result leaves in the same cycle, so that beat opens the next vector.
    assign in_ready    = (state_q == ST_ACC) | out_ready;
    assign beat_accept = in_valid & in_ready;

    assign prod_ext = {{(ACC_W-DATA_W){prod[DATA_W-1]}}, prod};
    assign acc_sum  = acc_q + prod_ext;

    acc_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_acc_sat (
        .acc_in   (acc_sum),
        .sat_out  (sat_val),
        .sat_flag (sat_flag)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        sat_d       = sat_q;
        case (state_q)
            ST_ACC: begin
                if (beat_accept) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        sum_d       = sat_val;
                        sat_d       = sat_flag;
                        acc_d       = '0;
                        beat_cnt_d  = '0;
                    end else begin
                        acc_d      = acc_sum;
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_ACC;
                    out_valid_d = 1'b0;
                    // acc is zero here, so a concurrent beat starts the vector.
                    if (in_valid) begin
                        acc_d      = prod_ext;
                        beat_cnt_d = 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign sat       = sat_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_signedmul_acc.sv
// Scoreboard bench for signedmul_acc (VEC_LEN=4): the driver feeds beats and
// pushes the expected saturated sum when a vector completes; an independent
// monitor compares every presented result.
module tb_signedmul_acc;

    localparam int DW = 16;
    localparam int VL = 4;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] prod = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] sum;
    logic          sat;
    logic [7:0]    beat_cnt;

    signedmul_acc #(.DATA_W(DW), .VEC_LEN(VL), .ACC_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .sat       (sat),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [DW-1:0] sum;
        logic          sat;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   cur_beats[$];
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random stalls, 2: driven by test
    bit   shown = 1'b0;
    int   n_results = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference: plain integer sum of the vector, then clip to Q3.12 range.
    task automatic close_vector();
        int   total;
        exp_t e;
        total = 0;
        foreach (cur_beats[i]) total += cur_beats[i];
        if (total > 32767) begin
            e.sum = 16'h7FFF; e.sat = 1'b1;
        end else if (total < -32768) begin
            e.sum = 16'h8000; e.sat = 1'b1;
        end else begin
            e.sum = 16'(total); e.sat = 1'b0;
        end
        e.cyc = cycle;
        sb.push_back(e);
        cur_beats.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send_beat(input logic [DW-1:0] p, input int bubbles);
        bit accepted;
        int waited;
        for (int b = 0; b < bubbles; b++) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        prod     = p;
        waited   = 0;
        accepted = 1'b0;
        while (!accepted) begin
            @(negedge clk);
            chk("beat_cnt", 32'(beat_cnt), 32'(cur_beats.size()));
            accepted = in_ready;
            @(posedge clk); #1;
            waited++;
            if (!accepted && waited > 200) begin
                chk("in_ready_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
        prod     = 16'($urandom);   // must be ignored while in_valid is low
        if (accepted) begin
            cur_beats.push_back(int'($signed(p)));
            if (cur_beats.size() == VL) close_vector();
        end
    endtask

    task automatic send_vec(input logic [DW-1:0] p0, p1, p2, p3, input int maxb);
        send_beat(p0, $urandom_range(0, maxb));
        send_beat(p1, $urandom_range(0, maxb));
        send_beat(p2, $urandom_range(0, maxb));
        send_beat(p3, $urandom_range(0, maxb));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    // Output-ready generator for the modes that are not test-driven.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 0) out_ready = 1'b1;
            else if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare every cycle a result is presented (also proves stability).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sb[0];
                    chk("sum", 32'(sum), 32'(e.sum));
                    chk("sat", 32'(sat), 32'(e.sat));
                    if (!shown) begin
                        chk("latency_cycle", 32'(cycle), 32'(e.cyc));
                        shown = 1'b1;
                    end
                    if (!out_ready) chk("in_ready_blocked", 32'(in_ready), 32'd0);
                    else begin
                        void'(sb.pop_front());
                        shown = 1'b0;
                        n_results++;
                        $display("result %0d: sum=%h sat=%0d", n_results, e.sum, e.sat);
                    end
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] r[4];
        // Reset state while asserted
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed vectors
        send_vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 0);
        send_vec(16'h7000, 16'h7000, 16'h7000, 16'h7000, 0);
        send_vec(16'h9000, 16'h9000, 16'h9000, 16'h9000, 0);
        send_vec(16'h1000, 16'hF000, 16'h0800, 16'hF800, 3);
        drain();

        // Pending result held off for 3 cycles while upstream is waiting
        ready_mode = 2;
        out_ready  = 1'b0;
        send_vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 0);
        fork
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            send_vec(16'h0400, 16'h0400, 16'h0400, 16'h0400, 0);
        join
        drain();
        ready_mode = 0;

        // Asynchronous reset in the middle of a vector
        send_beat(16'h2000, 0);
        send_beat(16'h2000, 0);
        reset = 1'b1;
        #1;
        chk("async_rst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        cur_beats.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        send_vec(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1);
        drain();

        // Random traffic with stalls on both sides
        ready_mode = 1;
        for (int v = 0; v < 1000; v++) begin
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0: r[k] = 16'($urandom_range(16'h6000, 16'h7FFF));
                    1: r[k] = 16'($urandom_range(16'h8000, 16'hA000));
                    default: r[k] = 16'($urandom);
                endcase
            end
            send_vec(r[0], r[1], r[2], r[3], 2);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
